// File: rtl/lhn_io_responder.sv
// CPU I/O responder: debounced switch input port, scratch registers, 4-deep LED output FIFO with timed display drain.
// Every access acks one cycle after its strobe; OPDR writes to a full FIFO with no pop pending are dropped and flagged.
module lhn_io_responder #(
    parameter int DEB_CYCLES = 4,
    parameter int DISP_HOLD  = 8
) (
    input  logic        Clock_pin,
    input  logic        Reset_pin,
    input  logic [3:0]  io_addr,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [13:0] io_wdata,
    output logic [13:0] io_rdata,
    output logic        io_ack,
    input  logic [4:0]  SW_pin,
    output logic [7:0]  Display_pin,
    output logic        out_full
);

    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int HCW = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;
    localparam logic [DCW-1:0] DEB_MAX   = DCW'(DEB_CYCLES);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(DISP_HOLD - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state_q;
    logic [HCW-1:0]  hold_cnt_q;
    logic [4:0]      sync1_q, sync2_q, cand_q, ipdr_q;
    logic [DCW-1:0]  deb_cnt_q;
    logic            sw_changed_q, overflow_q;
    logic            ack_q;
    logic [13:0]     rdata_q, rdata_d;
    logic [13:0]     scratch_q [4:15];
    logic [7:0]      mem_q [4];
    logic [1:0]      wr_ptr_q, rd_ptr_q;
    logic [2:0]      count_q;
    logic [7:0]      disp_q;

    logic full, empty, pop, push, drop, opdr_wr, ctrl_wr, deb_fire;
    logic [13:0] status;

    always_comb begin
        full     = (count_q == 3'd4);
        empty    = (count_q == 3'd0);
        pop      = (state_q == IDLE) && !empty;
        opdr_wr  = io_wr && (io_addr == 4'd2);
        ctrl_wr  = io_wr && (io_addr == 4'd3);
        // A pop in the same cycle frees the slot, so a write to a full FIFO is only lost without one.
        push     = opdr_wr && (!full || pop);
        drop     = opdr_wr && full && !pop;
        deb_fire = (deb_cnt_q == DEB_MAX) && (cand_q != ipdr_q);
        status   = {7'd0, count_q, overflow_q, empty, full, sw_changed_q};
        rdata_d  = 14'd0;
        if (io_rd && !io_wr) begin
            case (io_addr)
                4'd0:       rdata_d = {9'd0, ipdr_q};
                4'd1:       rdata_d = status;
                4'd2, 4'd3: rdata_d = 14'd0;
                default:    rdata_d = scratch_q[io_addr];
            endcase
        end
    end

    always_ff @(posedge Clock_pin or posedge Reset_pin) begin
        if (Reset_pin) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            cand_q       <= '0;
            ipdr_q       <= '0;
            deb_cnt_q    <= '0;
            sw_changed_q <= 1'b0;
            overflow_q   <= 1'b0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            disp_q       <= '0;
            for (int i = 4; i < 16; i++) scratch_q[i] <= '0;
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
        end else begin
            sync1_q <= SW_pin;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q    <= sync2_q;
                deb_cnt_q <= '0;
            end else if (deb_cnt_q != DEB_MAX) begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
            if (deb_fire) ipdr_q <= cand_q;

            // Set beats a simultaneous write-1-to-clear so an event is never lost.
            if (deb_fire)                       sw_changed_q <= 1'b1;
            else if (ctrl_wr && io_wdata[0])    sw_changed_q <= 1'b0;
            if (drop)                           overflow_q <= 1'b1;
            else if (ctrl_wr && io_wdata[3])    overflow_q <= 1'b0;

            ack_q   <= io_rd | io_wr;
            rdata_q <= rdata_d;
            if (io_wr && (io_addr >= 4'd4)) scratch_q[io_addr] <= io_wdata;

            if (push) begin
                mem_q[wr_ptr_q] <= io_wdata[7:0];
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        disp_q     <= mem_q[rd_ptr_q];
                        hold_cnt_q <= HOLD_LOAD;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    // Leaving as the count hits zero gives exactly DISP_HOLD cycles per entry.
                    if (hold_cnt_q <= HCW'(1)) begin
                        hold_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io_ack      = ack_q;
    assign io_rdata    = rdata_q;
    assign Display_pin = disp_q;
    assign out_full    = full;

endmodule

// File: tb/tb_lhn_io_responder.sv
// Directed bench for lhn_io_responder: register map, debounce, FIFO drain timing, overflow and reset abort.
module tb_lhn_io_responder;

    logic        Clock_pin = 1'b0;
    logic        Reset_pin = 1'b1;
    logic [3:0]  io_addr   = '0;
    logic        io_rd     = 1'b0;
    logic        io_wr     = 1'b0;
    logic [13:0] io_wdata  = '0;
    logic [13:0] io_rdata;
    logic        io_ack;
    logic [4:0]  SW_pin    = '0;
    logic [7:0]  Display_pin;
    logic        out_full;

    int checks = 0;
    int errors = 0;

    lhn_io_responder #(.DEB_CYCLES(4), .DISP_HOLD(8)) dut (
        .Clock_pin  (Clock_pin),
        .Reset_pin  (Reset_pin),
        .io_addr    (io_addr),
        .io_rd      (io_rd),
        .io_wr      (io_wr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_ack     (io_ack),
        .SW_pin     (SW_pin),
        .Display_pin(Display_pin),
        .out_full   (out_full)
    );

    always #5 Clock_pin = ~Clock_pin;

    // One access: strobe driven for one cycle, ack/rdata captured on the following negedge.
    task automatic do_acc(input logic rd, input logic wr, input logic [3:0] a,
                          input logic [13:0] d, output logic ack, output logic [13:0] rdat);
        @(negedge Clock_pin);
        io_rd = rd; io_wr = wr; io_addr = a; io_wdata = d;
        @(negedge Clock_pin);
        ack = io_ack; rdat = io_rdata;
        io_rd = 1'b0; io_wr = 1'b0;
    endtask

    task automatic test_reset;
        logic ack; logic [13:0] rd;
        repeat (3) @(negedge Clock_pin);
        checks++; if (io_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b expected 0", io_ack); end
        checks++; if (io_rdata !== 14'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", io_rdata); end
        checks++; if (Display_pin !== 8'd0) begin errors++; $display("FAIL reset_display: got %h expected 00", Display_pin); end
        checks++; if (out_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", out_full); end
        Reset_pin = 1'b0;
        do_acc(1'b1, 1'b0, 4'd1, 14'd0, ack, rd);
        checks++; if (ack !== 1'b1 || rd !== 14'h0004) begin errors++; $display("FAIL reset_status: ack %0b data %h expected ack 1 data 0004", ack, rd); end
    endtask

    task automatic test_scratch;
        logic ack; logic [13:0] rd;
        do_acc(1'b0, 1'b1, 4'd5, 14'h1ABC, ack, rd);
        checks++; if (ack !== 1'b1 || rd !== 14'd0) begin errors++; $display("FAIL scratch_write_ack: ack %0b data %h expected ack 1 data 0", ack, rd); end
        do_acc(1'b1, 1'b0, 4'd5, 14'd0, ack, rd);
        checks++; if (ack !== 1'b1 || rd !== 14'h1ABC) begin errors++; $display("FAIL scratch_read: ack %0b data %h expected ack 1 data 1abc", ack, rd); end
        @(negedge Clock_pin);
        checks++; if (io_ack !== 1'b0 || io_rdata !== 14'd0) begin errors++; $display("FAIL ack_single_cycle: ack %0b data %h expected ack 0 data 0", io_ack, io_rdata); end
        do_acc(1'b1, 1'b0, 4'd2, 14'd0, ack, rd);
        checks++; if (ack !== 1'b1 || rd !== 14'd0) begin errors++; $display("FAIL opdr_read_zero: ack %0b data %h expected ack 1 data 0", ack, rd); end
    endtask

    task automatic test_switch;
        logic ack; logic [13:0] rd;
        @(negedge Clock_pin); SW_pin = 5'b10101;
        repeat (10) @(negedge Clock_pin);
        do_acc(1'b1, 1'b0, 4'd0, 14'd0, ack, rd);
        checks++; if (rd !== 14'h0015) begin errors++; $display("FAIL ipdr_value: got %h expected 0015", rd); end
        do_acc(1'b1, 1'b0, 4'd1, 14'd0, ack, rd);
        checks++; if (rd !== 14'h0005) begin errors++; $display("FAIL sw_changed_set: status %h expected 0005", rd); end
        do_acc(1'b0, 1'b1, 4'd3, 14'h0001, ack, rd);
        do_acc(1'b1, 1'b0, 4'd1, 14'd0, ack, rd);
        checks++; if (rd !== 14'h0004) begin errors++; $display("FAIL sw_changed_clear: status %h expected 0004", rd); end
    endtask

    task automatic test_glitch;
        logic ack; logic [13:0] rd;
        @(negedge Clock_pin); SW_pin = 5'b01010;
        repeat (2) @(negedge Clock_pin);
        SW_pin = 5'b10101;
        repeat (10) @(negedge Clock_pin);
        do_acc(1'b1, 1'b0, 4'd0, 14'd0, ack, rd);
        checks++; if (rd !== 14'h0015) begin errors++; $display("FAIL glitch_ipdr: got %h expected 0015", rd); end
        do_acc(1'b1, 1'b0, 4'd1, 14'd0, ack, rd);
        checks++; if (rd !== 14'h0004) begin errors++; $display("FAIL glitch_status: got %h expected 0004", rd); end
    endtask

    task automatic test_rd_wr_both;
        logic ack; logic [13:0] rd;
        do_acc(1'b1, 1'b1, 4'd6, 14'h0007, ack, rd);
        checks++; if (ack !== 1'b1 || rd !== 14'd0) begin errors++; $display("FAIL both_strobes: ack %0b data %h expected ack 1 data 0", ack, rd); end
        do_acc(1'b1, 1'b0, 4'd6, 14'd0, ack, rd);
        checks++; if (rd !== 14'h0007) begin errors++; $display("FAIL both_scratch: got %h expected 0007", rd); end
    endtask

    task automatic test_fifo_drain;
        logic ack; logic [13:0] rd;
        @(negedge Clock_pin); io_wr = 1'b1; io_addr = 4'd2; io_wdata = 14'd1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge Clock_pin);
            if (cyc <= 5) begin
                checks++; if (io_ack !== 1'b1) begin errors++; $display("FAIL fifo_ack_%0d: got %0b expected 1", cyc, io_ack); end
            end
            if (cyc == 5) begin
                checks++; if (out_full !== 1'b1) begin errors++; $display("FAIL fifo_full: got %0b expected 1", out_full); end
            end
            for (int v = 1; v <= 5; v++) begin
                if (cyc == 8*v - 7) begin
                    checks++; if (Display_pin !== 8'(v-1)) begin errors++; $display("FAIL disp_before_%0d: got %h expected %h", v, Display_pin, 8'(v-1)); end
                end
                if (cyc == 8*v - 6) begin
                    checks++; if (Display_pin !== 8'(v)) begin errors++; $display("FAIL disp_show_%0d: got %h expected %h", v, Display_pin, 8'(v)); end
                end
            end
            if (cyc <= 4) io_wdata = 14'(cyc + 1);
            else io_wr = 1'b0;
        end
        repeat (10) @(negedge Clock_pin);
        do_acc(1'b1, 1'b0, 4'd1, 14'd0, ack, rd);
        checks++; if (rd !== 14'h0004) begin errors++; $display("FAIL fifo_no_overflow: status %h expected 0004", rd); end
    endtask

    task automatic test_overflow;
        logic ack; logic [13:0] rd;
        @(negedge Clock_pin); io_wr = 1'b1; io_addr = 4'd2; io_wdata = 14'h0011;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge Clock_pin);
            checks++; if (io_ack !== 1'b1) begin errors++; $display("FAIL ovf_ack_%0d: got %0b expected 1", cyc, io_ack); end
            if (cyc == 2) begin
                checks++; if (Display_pin !== 8'h11) begin errors++; $display("FAIL ovf_first_pop: got %h expected 11", Display_pin); end
            end
            if (cyc <= 5) io_wdata = 14'(8'h11 + cyc);
            else begin io_wr = 1'b0; io_rd = 1'b1; io_addr = 4'd1; end
        end
        @(negedge Clock_pin);
        checks++; if (io_ack !== 1'b1 || io_rdata !== 14'h004A) begin errors++; $display("FAIL ovf_status: ack %0b data %h expected ack 1 data 004a", io_ack, io_rdata); end
        io_rd = 1'b0;
        repeat (40) @(negedge Clock_pin);
        checks++; if (Display_pin !== 8'h15) begin errors++; $display("FAIL ovf_last_display: got %h expected 15", Display_pin); end
        do_acc(1'b0, 1'b1, 4'd3, 14'h0008, ack, rd);
        do_acc(1'b1, 1'b0, 4'd1, 14'd0, ack, rd);
        checks++; if (rd !== 14'h0004) begin errors++; $display("FAIL ovf_clear: status %h expected 0004", rd); end
    endtask

    task automatic test_reset_mid_hold;
        logic ack; logic [13:0] rd;
        @(negedge Clock_pin); SW_pin = 5'd0;
        repeat (12) @(negedge Clock_pin);
        io_wr = 1'b1; io_addr = 4'd2; io_wdata = 14'h0021;
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clock_pin); io_wdata = 14'(8'h21 + k);
        end
        @(negedge Clock_pin);
        io_wr = 1'b0; io_rd = 1'b1; io_addr = 4'd5;
        @(negedge Clock_pin);
        checks++; if (Display_pin !== 8'h21 || io_ack !== 1'b1) begin errors++; $display("FAIL pre_reset: disp %h ack %0b expected disp 21 ack 1", Display_pin, io_ack); end
        Reset_pin = 1'b1; io_rd = 1'b0;
        #1;
        checks++; if (io_ack !== 1'b0 || io_rdata !== 14'd0) begin errors++; $display("FAIL async_reset_ack: ack %0b data %h expected 0 0", io_ack, io_rdata); end
        checks++; if (Display_pin !== 8'd0 || out_full !== 1'b0) begin errors++; $display("FAIL async_reset_disp: disp %h full %0b expected 00 0", Display_pin, out_full); end
        @(negedge Clock_pin); Reset_pin = 1'b0;
        @(posedge Clock_pin); #1;
        checks++; if (io_ack !== 1'b0) begin errors++; $display("FAIL post_reset_ack: got %0b expected 0", io_ack); end
        repeat (10) @(negedge Clock_pin);
        checks++; if (Display_pin !== 8'd0) begin errors++; $display("FAIL post_reset_display: got %h expected 00", Display_pin); end
        do_acc(1'b1, 1'b0, 4'd1, 14'd0, ack, rd);
        checks++; if (rd !== 14'h0004) begin errors++; $display("FAIL post_reset_status: got %h expected 0004", rd); end
        do_acc(1'b1, 1'b0, 4'd5, 14'd0, ack, rd);
        checks++; if (rd !== 14'd0) begin errors++; $display("FAIL post_reset_scratch: got %h expected 0000", rd); end
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_switch();
        test_glitch();
        test_rd_wr_both();
        test_fifo_drain();
        test_overflow();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
